// File: rtl/gcd_pkg.sv
// Shared defaults and FSM encoding for the GCD operand feeder.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH = 8;
  localparam int unsigned GCD_DEPTH = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_RES = 3'd2,
    S_NEXT     = 3'd3,
    S_FIN      = 3'd4
  } gcd_state_e;

endpackage

// File: rtl/gcd_operand_feeder_if.sv
// Operand offer / result return handshake between the feeder and a GCD engine.
interface gcd_operand_feeder_if
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH
);

  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_ready;

  // Feeder side
  modport master (
    output op_valid, op_a, op_b, res_ready,
    input  op_ready, res_valid, res_data
  );

  // Engine side
  modport slave (
    input  op_valid, op_a, op_b, res_ready,
    output op_ready, res_valid, res_data
  );

endinterface

// File: rtl/gcd_pair_ram.sv
// Operand-pair table and result table; synchronous writes, combinational reads, no reset.
module gcd_pair_ram
  import gcd_pkg::*;
#(
  parameter  int unsigned WIDTH = GCD_WIDTH,
  parameter  int unsigned DEPTH = GCD_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             op_we,
  input  logic [AW-1:0]    op_waddr,
  input  logic [WIDTH-1:0] op_wa,
  input  logic [WIDTH-1:0] op_wb,
  input  logic [AW-1:0]    op_raddr,
  output logic [WIDTH-1:0] op_ra,
  output logic [WIDTH-1:0] op_rb,
  input  logic             res_we,
  input  logic [AW-1:0]    res_waddr,
  input  logic [WIDTH-1:0] res_wdata,
  input  logic [AW-1:0]    res_raddr,
  output logic [WIDTH-1:0] res_rdata
);

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Contents survive reset so a run can be repeated after an abort
  always_ff @(posedge clk) begin
    if (op_we) begin
      mem_a[op_waddr] <= op_wa;
      mem_b[op_waddr] <= op_wb;
    end
  end

  always_ff @(posedge clk) begin
    if (res_we) begin
      mem_r[res_waddr] <= res_wdata;
    end
  end

  assign op_ra     = mem_a[op_raddr];
  assign op_rb     = mem_b[op_raddr];
  assign res_rdata = mem_r[res_raddr];

endmodule

// File: rtl/gcd_operand_feeder.sv
// Walks a table of operand pairs, offers each to a GCD engine and stores the returned results.
module gcd_operand_feeder
  import gcd_pkg::*;
#(
  parameter  int unsigned WIDTH = GCD_WIDTH,
  parameter  int unsigned DEPTH = GCD_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW:0]          num_pairs,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_a,
  input  logic [WIDTH-1:0]     wr_b,
  gcd_operand_feeder_if.master eng,
  input  logic [AW-1:0]        rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic [AW-1:0]        pair_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 zero_err
);

  gcd_state_e       state_q, state_d;
  logic [AW:0]      np_q, np_d;
  logic [AW:0]      idx_inc;
  logic [AW-1:0]    idx_d;
  logic             zero_err_d;
  logic             done_d;
  logic             busy_d;
  logic             res_ready_q, res_ready_d;
  logic             op_valid_q, op_valid_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             res_we;
  logic [WIDTH-1:0] res_wdata;
  logic [WIDTH-1:0] tab_a, tab_b;
  logic             pair_zero;
  logic             op_we;

  // Table is frozen while a run is in progress
  assign op_we     = wr_en && (state_q == S_IDLE);
  assign pair_zero = (tab_a == '0) || (tab_b == '0);

  gcd_pair_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .op_we     (op_we),
    .op_waddr  (wr_addr),
    .op_wa     (wr_a),
    .op_wb     (wr_b),
    .op_raddr  (idx_d),
    .op_ra     (tab_a),
    .op_rb     (tab_b),
    .res_we    (res_we),
    .res_waddr (pair_idx),
    .res_wdata (res_wdata),
    .res_raddr (rd_addr),
    .res_rdata (rd_data)
  );

  // Next-state, counters and result-table write
  always_comb begin
    state_d    = state_q;
    np_d       = np_q;
    idx_d      = pair_idx;
    zero_err_d = zero_err;
    done_d     = 1'b0;
    res_we     = 1'b0;
    res_wdata  = '0;
    idx_inc    = (AW+1)'(pair_idx) + (AW+1)'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          np_d       = (num_pairs > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_pairs;
          idx_d      = '0;
          zero_err_d = 1'b0;
          state_d    = (num_pairs == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // op_valid_q low here means the entry held a zero operand
        if (!op_valid_q) begin
          zero_err_d = 1'b1;
          res_we     = 1'b1;
          state_d    = S_NEXT;
        end else if (eng.op_ready) begin
          state_d = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (eng.res_valid) begin
          res_we    = 1'b1;
          res_wdata = eng.res_data;
          state_d   = S_NEXT;
        end
      end
      S_NEXT: begin
        idx_d   = idx_inc[AW-1:0];
        state_d = (idx_inc == np_q) ? S_FIN : S_ISSUE;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Offer is loaded on entry to ISSUE and held until the transfer
  always_comb begin
    op_valid_d = 1'b0;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    if (state_d == S_ISSUE) begin
      if (state_q == S_ISSUE) begin
        op_valid_d = op_valid_q;
      end else begin
        op_valid_d = !pair_zero;
        op_a_d     = tab_a;
        op_b_d     = tab_b;
      end
    end
  end

  assign busy_d      = (state_d != S_IDLE);
  assign res_ready_d = (state_d == S_WAIT_RES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      np_q        <= '0;
      pair_idx    <= '0;
      zero_err    <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      res_ready_q <= 1'b0;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      np_q        <= np_d;
      pair_idx    <= idx_d;
      zero_err    <= zero_err_d;
      done        <= done_d;
      busy        <= busy_d;
      res_ready_q <= res_ready_d;
      op_valid_q  <= op_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
    end
  end

  assign eng.op_valid  = op_valid_q;
  assign eng.op_a      = op_a_q;
  assign eng.op_b      = op_b_q;
  assign eng.res_ready = res_ready_q;

endmodule

// File: doc/gcd_operand_feeder.md
GCD_OPERAND_FEEDER -- requirements
Module: gcd_operand_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of table entries (power of two); AW = log2(DEPTH).
REQ-003 The block SHALL have ports (name, direction, width, meaning) exactly as follows: one clock, clk; reset rst_n, asynchronous and active-low.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled in IDLE only.
- num_pairs  in  AW+1  pairs to process, sampled on accepted start.
- wr_en  in  1  operand table write strobe.
- wr_addr  in  AW  table write address.
- wr_a, wr_b  in  WIDTH  operand pair to write.
- op_valid  out  1  operand pair offered downstream.
- op_ready  in  1  GCD engine accepts pair.
- op_a, op_b  out  WIDTH  offered operands.
- res_valid  in  1  GCD engine result available.
- res_data  in  WIDTH  GCD result.
- res_ready  out  1  feeder accepts result.
- rd_addr  in  AW  result table read address.
- rd_data  out  WIDTH  result table entry, combinational read.
- pair_idx  out  AW  index of the current pair.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at run completion.
- zero_err  out  1  sticky; a pair with a zero operand was skipped.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT_RES, NEXT and FIN.
REQ-005 In IDLE, start=1 SHALL latch num_pairs, clear pair_idx and zero_err, and go to ISSUE, or to FIN if num_pairs=0.
REQ-006 In ISSUE, the block SHALL drive op_valid=1 with op_a/op_b equal to table[pair_idx].
- op_valid is asserted the cycle after start is accepted.
REQ-007 op_a/op_b SHALL stay stable while op_valid=1 and op_ready=0; op_valid SHALL NOT deassert before transfer.
REQ-008 A transfer SHALL occur on a cycle with op_valid and op_ready both high; the FSM then SHALL go to WAIT_RES.
REQ-009 If table[pair_idx] has either operand equal to 0, ISSUE SHALL NOT assert op_valid, SHALL set zero_err, SHALL write 0 to result[pair_idx], and SHALL go to NEXT.
REQ-010 res_ready SHALL be 1 only in WAIT_RES; on res_valid=1 it SHALL write res_data to result[pair_idx] and go to NEXT.
REQ-011 res_valid outside WAIT_RES SHALL be ignored, with no write and no state change.
REQ-012 NEXT SHALL increment pair_idx, then go to FIN when the incremented count equals the latched num_pairs, else to ISSUE.
- num_pairs > DEPTH is clamped to DEPTH.
REQ-013 FIN SHALL pulse done for exactly one cycle and return to IDLE; busy SHALL drop in the same cycle as the return to IDLE.
REQ-014 start while busy=1 SHALL be ignored.
REQ-015 wr_en while busy=1 SHALL be ignored; a write in IDLE SHALL take effect on the next edge.
REQ-016 rd_data SHALL reflect result[rd_addr] combinationally at all times.
REQ-017 Minimum run length for N non-zero pairs with zero wait states SHALL be 1 + 3N + 1 cycles from start to done.

Reset
REQ-018 rst_n=0 SHALL immediately force IDLE, with op_valid=0, res_ready=0, busy=0, done=0, zero_err=0, pair_idx=0 and op_a=op_b=0.
REQ-019 Operand and result tables SHALL NOT be reset; their contents SHALL be retained across reset.
REQ-020 Reset asserted mid-run, including with op_valid high, SHALL abandon the run with no done pulse; a later start SHALL run normally.

Structure
REQ-021 Package gcd_pkg SHALL hold WIDTH/DEPTH defaults and the FSM state enumeration.
REQ-022 The operand and result storage SHALL be one sub-module, gcd_pair_ram: write port, registered-free combinational read.

Verification
REQ-023 Load (48,18),(35,14),(17,5), num_pairs=3, immediate ready, responder returns 6,7,1:
- rd_data[0..2] = 6,7,1.
- One done pulse.
- zero_err=0.
- 11 cycles from start to done.
REQ-024 Hold op_ready=0 for 5 cycles on pair (48,18): op_valid stays high and op_a=48/op_b=18 stay constant; transfer occurs on the first ready cycle.
REQ-025 Pairs (0,9),(12,8), num_pairs=2:
- First pair skipped and never offered.
- zero_err=1.
- result[0]=0, result[1]=4.
REQ-026 num_pairs=0, start: done pulses 2 cycles after start; op_valid never asserts.
REQ-027 rst_n low for 1 cycle while in WAIT_RES:
- All outputs take reset values asynchronously.
- A spurious res_valid after reset is ignored.
- Re-running the REQ-023 run reproduces its results.
